// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants for the pipeline control unit.
//   - stall vector bit indices (pc, if, id, ex, mem, wb)
//   - canned stall vectors, one per stall source
//   - FSM state encoding for pipe_ctrl
// The stage indices keep the plain STALL_<stage> names. The whole-vector
// constants therefore carry a STALL_VEC_ prefix so the two sets cannot collide.
package pipe_ctrl_pkg;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  // A stall freezes the requesting stage and everything upstream of it.
  localparam logic [5:0] STALL_VEC_NONE = 6'b000000;
  localparam logic [5:0] STALL_VEC_ID   = 6'b000111;
  localparam logic [5:0] STALL_VEC_EX   = 6'b001111;
  localparam logic [5:0] STALL_VEC_MEM  = 6'b011111;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_EXBUSY = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the 5-stage RV32I core.
// It arbitrates three stall sources: ID load-use, the multi-cycle EX unit and
// the data memory. It drives the per-stage hold vector and flushes IF/ID when
// ID resolves a taken branch or jump.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   id_stallreq_i     ID bubble request (level)
//   ex_mc_start_i     EX multi-cycle op start (one-cycle pulse)
//   ex_mc_cycles_i    total EX occupancy N of that op
//   mem_stallreq_i    data memory not ready (level)
//   branch_flag_i     ID branch/jump taken
//   stall_o           hold vector; bit0=pc .. bit5=wb
//   if_flush_o        load NOP into IF/ID
//   ex_mc_done_o      last cycle of the multi-cycle op
//   busy_o            FSM is in S_EXBUSY
//   stall_cyc_o       (PIPE_CTRL_PERF_EN) cycles with stall_o[0]=1
//   flush_cnt_o       (PIPE_CTRL_PERF_EN) cycles with if_flush_o=1
//
// Optional feature macro: PIPE_CTRL_PERF_EN adds the two performance counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_RUN    | no multi-cycle op outstanding; a start can be accepted
// S_EXBUSY | multi-cycle op in flight; cnt = cycles left including now
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int STALL_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_stallreq_i,
  input  logic               ex_mc_start_i,
  input  logic [CNT_W-1:0]   ex_mc_cycles_i,
  input  logic               mem_stallreq_i,
  input  logic               branch_flag_i,
  output logic [STALL_W-1:0] stall_o,
  output logic               if_flush_o,
  output logic               ex_mc_done_o,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]        stall_cyc_o,
  output logic [31:0]        flush_cnt_o,
`endif
  output logic               busy_o
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             ex_stall;
  logic [5:0]       stall_vec;

  // A start arriving under a mem stall is dropped, not queued.
  // EX re-pulses start once memory is ready.
  assign accept = ex_mc_start_i && (state == S_RUN) && !mem_stallreq_i
                  && (ex_mc_cycles_i != '0);

  assign ex_stall = accept || (state == S_EXBUSY);

  always_comb begin
    stall_vec = STALL_VEC_NONE;
    if (rst)                 stall_vec = STALL_VEC_NONE;
    else if (mem_stallreq_i) stall_vec = STALL_VEC_MEM;
    else if (ex_stall)       stall_vec = STALL_VEC_EX;
    else if (id_stallreq_i)  stall_vec = STALL_VEC_ID;
  end

  assign stall_o = stall_vec;

  // A branch held in ID waits for ID to advance, because its operands may be stale.
  assign if_flush_o = !rst && branch_flag_i && !stall_vec[STALL_ID];

  assign ex_mc_done_o = !rst && ((accept && ex_mc_cycles_i == CNT_W'(1)) ||
                                 (state == S_EXBUSY && cnt == CNT_W'(1)));

  assign busy_o = !rst && (state == S_EXBUSY);

  // The counter runs regardless of mem stalls, because the EX unit is free-running.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (accept && ex_mc_cycles_i != CNT_W'(1)) begin
            state <= S_EXBUSY;
            cnt   <= ex_mc_cycles_i - CNT_W'(1);
          end
        end
        S_EXBUSY: begin
          if (cnt == CNT_W'(1)) begin
            state <= S_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= S_RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cyc_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_vec[STALL_PC]) stall_cyc_o <= stall_cyc_o + 32'd1;
      if (if_flush_o)          flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam int CNT_W   = 4;
  localparam int STALL_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_stallreq_i;
  logic             ex_mc_start_i;
  logic [CNT_W-1:0] ex_mc_cycles_i;
  logic             mem_stallreq_i;
  logic             branch_flag_i;
  logic [STALL_W-1:0] stall_o;
  logic             if_flush_o;
  logic             ex_mc_done_o;
  logic             busy_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]      stall_cyc_o;
  logic [31:0]      flush_cnt_o;
`endif

  pipe_ctrl #(.CNT_W(CNT_W), .STALL_W(STALL_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_stallreq_i  (id_stallreq_i),
    .ex_mc_start_i  (ex_mc_start_i),
    .ex_mc_cycles_i (ex_mc_cycles_i),
    .mem_stallreq_i (mem_stallreq_i),
    .branch_flag_i  (branch_flag_i),
    .stall_o        (stall_o),
    .if_flush_o     (if_flush_o),
    .ex_mc_done_o   (ex_mc_done_o),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cyc_o    (stall_cyc_o),
    .flush_cnt_o    (flush_cnt_o),
`endif
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: the EX unit is busy for the "rem" future cycles still owed by the op.
  int          rem = 0;
  logic [31:0] m_stall_cyc = 0;
  logic [31:0] m_flush_cnt = 0;

  logic [5:0] e_stall;
  logic       e_flush, e_done, e_busy, e_acc;

  typedef struct {
    logic       r, id, st;
    logic [3:0] n;
    logic       m, b;
    logic [5:0] es;
    logic       ef, ed, eb;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_eval();
    e_acc   = !rst && ex_mc_start_i && rem == 0 && !mem_stallreq_i && ex_mc_cycles_i != 0;
    e_stall = 6'b000000;
    e_flush = 1'b0;
    e_done  = 1'b0;
    e_busy  = 1'b0;
    if (!rst) begin
      e_busy = rem > 0;
      if (mem_stallreq_i)         e_stall = 6'b011111;
      else if (e_acc || rem > 0)  e_stall = 6'b001111;
      else if (id_stallreq_i)     e_stall = 6'b000111;
      e_flush = branch_flag_i && !e_stall[2];
      e_done  = (e_acc && ex_mc_cycles_i == 1) || rem == 1;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      rem = 0;
      m_stall_cyc = 0;
      m_flush_cnt = 0;
    end else begin
      if (e_acc) rem = int'(ex_mc_cycles_i) - 1;
      else if (rem > 0) rem--;
      if (e_stall[0]) m_stall_cyc++;
      if (e_flush)    m_flush_cnt++;
    end
  endtask

  task automatic drive(input logic r, id, st, input logic [3:0] n, input logic m, b);
    rst = r; id_stallreq_i = id; ex_mc_start_i = st;
    ex_mc_cycles_i = n; mem_stallreq_i = m; branch_flag_i = b;
  endtask

  task automatic check_perf();
`ifdef PIPE_CTRL_PERF_EN
    chk("stall_cyc", stall_cyc_o, m_stall_cyc);
    chk("flush_cnt", flush_cnt_o, m_flush_cnt);
`endif
  endtask

  function automatic vec_t mk(logic r, id, st, logic [3:0] n, logic m, b,
                              logic [5:0] es, logic ef, ed, eb);
    vec_t v;
    v.r = r; v.id = id; v.st = st; v.n = n; v.m = m; v.b = b;
    v.es = es; v.ef = ef; v.ed = ed; v.eb = eb;
    return v;
  endfunction

  initial begin
    drive(1, 0, 0, 0, 0, 0);

    //          r  id st n  m  b   stall      fl dn bz
    // reset with every input high
    tbl.push_back(mk(1, 1, 1, 15, 1, 1, 6'b000000, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 15, 1, 1, 6'b000000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 6'b000000, 0, 0, 0));
    // ID bubble
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 6'b000111, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 6'b000000, 0, 0, 0));
    // N=4
    tbl.push_back(mk(0, 0, 1, 4,  0, 0, 6'b001111, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 6'b001111, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 6'b001111, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 6'b001111, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 6'b000000, 0, 0, 0));
    // N=1, then N=0
    tbl.push_back(mk(0, 0, 1, 1,  0, 0, 6'b001111, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 6'b000000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  0, 0, 6'b000000, 0, 0, 0));
    // branch alone, branch with id stall
    tbl.push_back(mk(0, 0, 0, 0,  0, 1, 6'b000000, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0, 1, 6'b000111, 0, 0, 0));
    // branch held through an N=2 op
    tbl.push_back(mk(0, 0, 1, 2,  0, 1, 6'b001111, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 1, 6'b001111, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 1, 6'b000000, 1, 0, 0));
    // N=5 with mem stall t+2..t+6 and an ignored start at t+5
    tbl.push_back(mk(0, 0, 1, 5,  0, 0, 6'b001111, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 6'b001111, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,  1, 0, 6'b011111, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,  1, 0, 6'b011111, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,  1, 0, 6'b011111, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 3,  1, 0, 6'b011111, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 0, 6'b011111, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 6'b000000, 0, 0, 0));
    // N=8 aborted by reset at t+3
    tbl.push_back(mk(0, 0, 1, 8,  0, 0, 6'b001111, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 6'b001111, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 6'b001111, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 6'b000000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 6'b000000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 6'b000000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 6'b000000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 6'b000000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 6'b000000, 0, 0, 0));

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].id, tbl[i].st, tbl[i].n, tbl[i].m, tbl[i].b);
      @(negedge clk);
      model_eval();
      chk($sformatf("vec%0d stall", i), 32'(stall_o),      32'(tbl[i].es));
      chk($sformatf("vec%0d flush", i), 32'(if_flush_o),   32'(tbl[i].ef));
      chk($sformatf("vec%0d done",  i), 32'(ex_mc_done_o), 32'(tbl[i].ed));
      chk($sformatf("vec%0d busy",  i), 32'(busy_o),       32'(tbl[i].eb));
      check_perf();
      @(posedge clk);
      model_step();
      #1;
    end

    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
      @(negedge clk);
      model_eval();
      chk("rnd stall", 32'(stall_o),      32'(e_stall));
      chk("rnd flush", 32'(if_flush_o),   32'(e_flush));
      chk("rnd done",  32'(ex_mc_done_o), 32'(e_done));
      chk("rnd busy",  32'(busy_o),       32'(e_busy));
      check_perf();
      @(posedge clk);
      model_step();
      #1;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
